// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: opcodes, instruction fields, flag indices and
// the sequencer state encoding.
package tiny16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned ST_W   = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_RSV = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_MUL = 4'h5;
  localparam logic [OP_W-1:0] OP_DIV = 4'h6;
  localparam logic [OP_W-1:0] OP_AND = 4'h7;
  localparam logic [OP_W-1:0] OP_OR  = 4'h8;
  localparam logic [OP_W-1:0] OP_XOR = 4'h9;
  localparam logic [OP_W-1:0] OP_SHL = 4'hA;
  localparam logic [OP_W-1:0] OP_SHR = 4'hB;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned AR_BIT  = 2;

  localparam int unsigned FLG_O = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_Z = 0;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] ST_EXEC  = 2'd2;
  localparam logic [ST_W-1:0] ST_WB    = 2'd3;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8x16 register file: one write port, two operand read ports and a debug
// read port, all reads combinational.
module regfile8x16
  import tiny16_pkg::*;
#(
  parameter int unsigned NREGS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [REG_AW-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [REG_AW-1:0]   raddr1,
  input  logic [REG_AW-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the external ALU: decodes one instruction per
// handshake, runs the compute/latch protocol and writes the result back.
module alu_sequencer
  import tiny16_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned IMM_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_opcode,
  output logic        alu_ar_flag,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic        alu_out_en,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags_q,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [ST_W-1:0]   state, state_n;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd, rs1, rs2, rd_q;
  logic [DATA_W-1:0] rdata1, rdata2, res_q;
  logic [FLAG_W-1:0] flg_cap;
  logic              wr_q, upd_q, we;
  logic              accept, div0, dec_alu, dec_err;

  assign op  = instr[OP_LSB +: OP_W];
  assign rd  = instr[RD_LSB +: REG_AW];
  assign rs1 = instr[RS1_LSB +: REG_AW];
  assign rs2 = instr[RS2_LSB +: REG_AW];
  assign we  = (state == ST_WB) && wr_q;

  regfile8x16 #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Decode and next-state; divide-by-zero is caught here so the ALU never sees it
  always_comb begin
    accept  = (state == ST_IDLE) && instr_valid;
    div0    = (op == OP_DIV) && (rdata2 == '0);
    dec_alu = is_alu_op(op) && !div0;
    dec_err = div0 || (op > OP_SHR);
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = dec_alu ? ST_ISSUE : ST_WB;
      ST_ISSUE: state_n = ST_EXEC;
      ST_EXEC:  state_n = ST_WB;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b1;
      alu_opcode  <= '0;
      alu_ar_flag <= 1'b0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      alu_out_en  <= 1'b0;
      flags_q     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      upd_q       <= 1'b0;
      res_q       <= '0;
      flg_cap     <= '0;
    end else begin
      instr_ready <= (state_n == ST_IDLE);
      alu_out_en  <= (state_n == ST_EXEC);
      done        <= (state_n == ST_WB);
      err         <= accept && dec_err;
      if (accept) begin
        rd_q  <= rd;
        wr_q  <= dec_alu || (op == OP_LDI);
        upd_q <= dec_alu;
        res_q <= DATA_W'(instr[IMM_W-1:0]);
        if (dec_alu) begin
          alu_opcode  <= op;
          alu_ar_flag <= instr[AR_BIT];
          alu_src1    <= rdata1;
          alu_src2    <= rdata2;
        end
      end
      // ALU latched on the EXEC negedge; its outputs are stable by the closing edge
      if (state == ST_EXEC) begin
        res_q   <= alu_out;
        flg_cap <= alu_flags;
      end
      if ((state == ST_WB) && upd_q) flags_q <= flg_cap;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub, transaction-level reference model with a
// per-cycle compare, and directed programs with literal expectations.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [3:0]  alu_opcode;
  logic        alu_ar_flag;
  logic [15:0] alu_src1, alu_src2;
  logic        alu_out_en;
  logic [15:0] alu_out = '0;
  logic [3:0]  alu_flags = '0;
  logic [3:0]  flags_q;
  logic        done, err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_ar_flag (alu_ar_flag),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_out_en  (alu_out_en),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // ALU behaviour: returns {O,C,N,Z, result}
  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic ar,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] r;
    logic c, o;
    t = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'h3: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
                  o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h4: begin r = a - b; c = (a < b); o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h5: r = a * b;
      4'h6: r = (b == 0) ? 16'h0 : a / b;
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: begin t = {1'b0, a} << b[3:0]; r = t[15:0]; c = t[16]; end
      4'hB: r = ar ? 16'($signed(a) >>> b[3:0]) : (a >> b[3:0]);
      default: r = '0;
    endcase
    return {o, c, r[15], (r == 16'h0), r};
  endfunction

  logic [19:0] alu_int = '0;
  always @(posedge clk) alu_int <= alu_f(alu_opcode, alu_ar_flag, alu_src1, alu_src2);
  always @(negedge clk) if (alu_out_en) {alu_flags, alu_out} <= alu_int;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] s1, input logic [2:0] s2,
                                      input logic ar);
    return {op, rd, s1, s2, ar, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h1, rd, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted instruction becomes a pending transaction
  // that retires on a known edge and then updates the architectural state.
  int unsigned cyc = 0;
  bit          pend = 1'b0, p_alu, p_err, p_wr, p_upd, p_ar;
  int unsigned p_ret;
  logic [2:0]  p_rd;
  logic [3:0]  p_op, p_flags;
  logic [15:0] p_val, p_a, p_b;
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags = '0;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    logic [3:0]  op;
    logic [19:0] r;
    cyc = cyc + 1;
    if (rst) begin
      pend = 1'b0;
      m_flags = '0;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
    end else if (pend) begin
      if (cyc == p_ret) begin
        if (p_wr)  m_regs[p_rd] = p_val;
        if (p_upd) m_flags = p_flags;
        pend = 1'b0;
      end
    end else if (instr_valid) begin
      op    = instr[15:12];
      p_op  = op;
      p_rd  = instr[11:9];
      p_ar  = instr[2];
      p_a   = m_regs[instr[8:6]];
      p_b   = m_regs[instr[5:3]];
      p_err = (op >= 4'hC) || (op == 4'h6 && p_b == 16'h0);
      p_alu = (op >= 4'h3) && (op <= 4'hB) && !p_err;
      p_upd = p_alu;
      p_wr  = p_alu || (op == 4'h1);
      r     = alu_f(op, p_ar, p_a, p_b);
      p_val = (op == 4'h1) ? {7'b0, instr[8:0]} : r[15:0];
      p_flags = r[19:16];
      p_ret = cyc + (p_alu ? 3 : 1);
      pend  = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit exp_en;
    if (chk_on) begin
      exp_en = pend && p_alu && (cyc + 2 == p_ret);
      chk("instr_ready", instr_ready, !pend);
      chk("done", done, pend && (cyc + 1 == p_ret));
      chk("err", err, pend && (cyc + 1 == p_ret) && p_err);
      chk("alu_out_en", alu_out_en, exp_en);
      chk("flags_q", flags_q, m_flags);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      if (exp_en) begin
        chk("alu_opcode", alu_opcode, p_op);
        chk("alu_ar_flag", alu_ar_flag, p_ar);
        chk("alu_src1", alu_src1, p_a);
        chk("alu_src2", alu_src2, p_b);
      end
    end
  end

  task automatic issue(input logic [15:0] ins, output int lat, output bit err_seen);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 0;
    err_seen = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (done) begin
        lat = n;
        err_seen = err;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] v, output logic [3:0] f);
    @(posedge clk);
    #2 dbg_addr = a;
    #1 v = dbg_data;
    f = flags_q;
  endtask

  task automatic hold(input logic [15:0] ins, input int n, output int dones);
    dones = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = ins;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    int lat, nd;
    bit e;
    logic [15:0] v;
    logic [3:0] f;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_ready", instr_ready, 1'b1);
    rst = 1'b0;

    issue(ldi(3'd1, 9'd5), lat, e);  chk("ldi_lat", lat, 1);
    issue(ldi(3'd2, 9'd3), lat, e);
    issue(enc(4'h3, 3'd3, 3'd1, 3'd2, 1'b0), lat, e);
    chk("add_lat", lat, 3);
    rd_reg(3'd3, v, f);  chk("add_r3", v, 16'h0008);  chk("add_flags", f, 4'b0000);

    issue(ldi(3'd1, 9'd0), lat, e);
    issue(ldi(3'd2, 9'd1), lat, e);
    issue(enc(4'h4, 3'd3, 3'd1, 3'd2, 1'b0), lat, e);
    rd_reg(3'd3, v, f);  chk("sub_r3", v, 16'hFFFF);  chk("sub_flags", f, 4'b0110);

    issue(ldi(3'd1, 9'd1), lat, e);
    issue(enc(4'hA, 3'd2, 3'd1, 3'd1, 1'b0), lat, e);
    rd_reg(3'd2, v, f);  chk("shl_r2", v, 16'h0002);  chk("shl_flags", f, 4'b0000);
    issue(enc(4'h9, 3'd2, 3'd2, 3'd2, 1'b0), lat, e);
    rd_reg(3'd2, v, f);  chk("xor_r2", v, 16'h0000);  chk("xor_flags", f, 4'b0001);

    issue(ldi(3'd2, 9'd0), lat, e);
    issue(enc(4'h6, 3'd3, 3'd1, 3'd2, 1'b0), lat, e);
    chk("div0_lat", lat, 1);  chk("div0_err", e, 1'b1);
    rd_reg(3'd3, v, f);  chk("div0_r3", v, 16'hFFFF);  chk("div0_flags", f, 4'b0001);

    issue(enc(4'hE, 3'd3, 3'd1, 3'd1, 1'b0), lat, e);
    chk("ill_lat", lat, 1);  chk("ill_err", e, 1'b1);
    rd_reg(3'd3, v, f);  chk("ill_r3", v, 16'hFFFF);
    issue(enc(4'h0, 3'd3, 3'd0, 3'd0, 1'b0), lat, e);
    chk("nop_lat", lat, 1);  chk("nop_err", e, 1'b0);

    issue(ldi(3'd7, 9'h1FF), lat, e);
    rd_reg(3'd7, v, f);  chk("ldi_max", v, 16'h01FF);

    hold(enc(4'h3, 3'd4, 3'd1, 3'd2, 1'b0), 12, nd);
    chk("hold_dones", nd, 3);
    rd_reg(3'd4, v, f);  chk("hold_r4", v, 16'h0001);

    // Reset while an ADD is in EXEC
    issue(ldi(3'd2, 9'd3), lat, e);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(4'h3, 3'd6, 3'd1, 3'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_out_en", alu_out_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    rd_reg(3'd6, v, f);  chk("rst_r6", v, 16'h0000);  chk("rst_flags", f, 4'b0000);
    repeat (3) @(negedge clk);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-level controller that drives the ALU's operand/opcode interface and consumes its result and flags. Accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 8×16 register file. It sequences the ALU's posedge-compute / negedge-latch protocol, then writes the result back and holds the O C N Z flags for downstream branch logic.

## Interface
Parameters:
- `NREGS`, 8: register file depth; fixed to 8 because of 3-bit register fields.
- `IMM_W`, 9: width of the LDI immediate, zero-extended to 16.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer can accept.
- `instr` in 16: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [2] ar, [1:0] reserved. For LDI, [8:0] is the immediate.
- `alu_opcode` out 4: to ALU `opcode`.
- `alu_ar_flag` out 1: to ALU `ar_flag`.
- `alu_src1` out 16, `alu_src2` out 16: ALU operands.
- `alu_out_en` out 1: ALU output latch enable.
- `alu_out` in 16: ALU result.
- `alu_flags` in 4: ALU flags {O,C,N,Z}.
- `flags_q` out 4: last committed ALU flags.
- `done` out 1: one-cycle pulse when an instruction retires.
- `err` out 1: one-cycle pulse for an illegal opcode or divide-by-zero.
- `dbg_addr` in 3: debug register select.
- `dbg_data` out 16: combinational read of `regs[dbg_addr]`.

## Operation
- States: IDLE, ISSUE, EXEC, WB.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`, latch `instr` and decode.
- Decode by op:
  - op 0000 (NOP) and 0010 (reserved): go to WB with no write.
  - op 0001 (LDI): go to WB; write `regs[rd]` = {7'b0, instr[8:0]}. `flags_q` is unchanged.
  - op 0011–1011 (ALU ops): go to ISSUE. On the same edge, register `alu_opcode`=op, `alu_ar_flag`=instr[2], `alu_src1`=regs[rs1], `alu_src2`=regs[rs2].
  - op 0110 (divide) with regs[rs2]==0: go to WB with `err`; `rd` and `flags_q` are unchanged.
  - op 1100–1111 (illegal): go to WB with `err`; no write.
- ISSUE: operands are held stable; the ALU computes on the closing posedge.
- EXEC:
  - `alu_out_en`=1; the ALU latches out/flags on the mid-cycle negedge.
  - On the closing posedge, capture `alu_out` and `alu_flags`.
- WB:
  - Write the captured result to `regs[rd]` and load `flags_q` (ALU ops only).
  - `done`=1; `err` as decided at decode; return to IDLE.
- Outside EXEC, `alu_opcode`/`alu_src*` keep their last values. `alu_out_en`=0.
- Register writes take effect at the end of WB. The next instruction can be accepted in the following IDLE cycle and sees the new value (no forwarding needed).
- `rd`, `rs1` and `rs2` may alias; operands are read at decode, before any write.

## Timing
- Reset values:
  - State IDLE; `instr_ready`=1 after reset deasserts.
  - `alu_opcode`=0, `alu_ar_flag`=0, `alu_src1`=0, `alu_src2`=0, `alu_out_en`=0.
  - `flags_q`=0, `done`=0, `err`=0, all regs=0.
- Latency:
  - ALU op: accept edge T, ISSUE in cycle T+1, EXEC in T+2, WB (`done`) in T+3. Throughput is one instruction per 4 cycles.
  - Non-ALU op: accept T, WB in T+1, i.e. one per 2 cycles.
- `instr_ready` is low in ISSUE, EXEC and WB. An `instr_valid` held during those cycles is not consumed.
- `rst` mid-operation: return to IDLE on the next edge. The in-flight instruction is discarded, no write occurs, and `done`/`err` stay 0.
- Arithmetic: results are truncated to 16 bits by the ALU. The carry appears only in `flags_q[2]`.

## Structure
- Shared package `tiny16_pkg`:
  - Opcode constants: OP_NOP, OP_LDI, OP_ADD … OP_SHR.
  - Instruction field positions.
  - Flag bit indices: FLG_O=3, FLG_C=2, FLG_N=1, FLG_Z=0.
  - State enum.
- One sub-module, `regfile8x16`: one write port, two combinational read ports (rs1, rs2) plus a debug read port, synchronous reset to zero.

## Test plan
- LDI r1,5; LDI r2,3; ADD r3,r1,r2 → r3=8, `flags_q`=0000, `done` at T+3, `alu_out_en` high exactly in EXEC.
- LDI r1,0; LDI r2,1; SUB r3,r1,r2 → r3=FFFF, `flags_q` N=1, C=1.
- LDI r1,1; SHL r2,r1,r1 with ar=0 → r2=0002. Then XOR r2,r2,r2 → r2=0000, Z=1.
- LDI r2,0; DIV r3,r1,r2 → `err` pulse, r3 unchanged, `flags_q` unchanged, no `alu_out_en`.
- Illegal op 1110 → `err`+`done` at T+1, no register change. Hold `instr_valid` high through a busy period → exactly one accept per IDLE.
- Assert `rst` during EXEC of ADD → no `done`, rd remains 0, `instr_ready`=1 one cycle after `rst` deasserts.
